imm_encoder: RTL and testbench

- Inverse of the immediate extender: packs a 32-bit signed or unsigned immediate into the scattered instruction bit fields for the I, S, B, J or U format.
- Merges the packed fields into an instruction template and flags immediates that cannot be encoded.
- Serves the instruction-memory preload/self-test path, which builds instruction words on chip.
- Two-stage valid/ready pipeline with backpressure and a saturating error counter.

---
 rtl/imm_encoder.sv | 165 ++++++++++++++++
 tb/tb_imm_encoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the I/S/B/J/U instruction fields of a template word and flags unencodable values.
// Two-stage valid/ready pipeline (2-cycle latency, 1/cycle throughput) with a saturating error counter.
module imm_encoder #(
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      immsrc,
    input  logic [31:0]     imm,
    input  logic [31:0]     tmpl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [1:0]      out_err,
    output logic [ERRW-1:0] err_count,
    input  logic            err_clr
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_SRC   = 2'b11;

    logic            s1_vld_q, s1_vld_d;
    logic [2:0]      s1_src_q;
    logic [31:0]     s1_imm_q;
    logic [31:0]     s1_tmpl_q;

    logic            out_vld_q, out_vld_d;
    logic [31:0]     out_instr_q;
    logic [1:0]      out_err_q;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    logic            accept;
    logic            s2_load;
    logic [31:0]     pk_instr;
    logic            range_bad;
    logic            misal;
    logic            bad_src;
    logic [1:0]      pk_err;

    assign s2_load  = s1_vld_q & (~out_vld_q | out_ready);
    assign in_ready = ~s1_vld_q | s2_load;
    assign accept   = in_valid & in_ready;

    always_comb begin
        s1_vld_d = s1_vld_q;
        if (accept) begin
            s1_vld_d = 1'b1;
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_src_q  <= 3'b000;
            s1_imm_q  <= 32'h0;
            s1_tmpl_q <= 32'h0;
        end else begin
            s1_vld_q <= s1_vld_d;
            if (accept) begin
                s1_src_q  <= immsrc;
                s1_imm_q  <= imm;
                s1_tmpl_q <= tmpl;
            end
        end
    end

    // Range checks test that the bits above the field's sign bit are all copies of it.
    always_comb begin
        pk_instr  = s1_tmpl_q;
        range_bad = 1'b0;
        misal     = 1'b0;
        bad_src   = 1'b0;
        case (s1_src_q)
            SRC_I: begin
                pk_instr[31:20] = s1_imm_q[11:0];
                range_bad = (s1_imm_q[31:11] != '0) && (s1_imm_q[31:11] != '1);
            end
            SRC_S: begin
                pk_instr[31:25] = s1_imm_q[11:5];
                pk_instr[11:7]  = s1_imm_q[4:0];
                range_bad = (s1_imm_q[31:11] != '0) && (s1_imm_q[31:11] != '1);
            end
            SRC_B: begin
                pk_instr[31]    = s1_imm_q[12];
                pk_instr[30:25] = s1_imm_q[10:5];
                pk_instr[11:8]  = s1_imm_q[4:1];
                pk_instr[7]     = s1_imm_q[11];
                range_bad = (s1_imm_q[31:12] != '0) && (s1_imm_q[31:12] != '1);
                misal     = s1_imm_q[0];
            end
            SRC_J: begin
                pk_instr[31]    = s1_imm_q[20];
                pk_instr[30:21] = s1_imm_q[10:1];
                pk_instr[20]    = s1_imm_q[11];
                pk_instr[19:12] = s1_imm_q[19:12];
                range_bad = (s1_imm_q[31:20] != '0) && (s1_imm_q[31:20] != '1);
                misal     = s1_imm_q[0];
            end
            SRC_U: begin
                pk_instr[31:12] = s1_imm_q[31:12];
                range_bad = (s1_imm_q[11:0] != 12'h000);
            end
            default: begin
                bad_src = 1'b1;
            end
        endcase
    end

    assign pk_err = bad_src   ? ERR_SRC   :
                    misal     ? ERR_ALIGN :
                    range_bad ? ERR_RANGE : ERR_OK;

    always_comb begin
        out_vld_d = out_vld_q;
        if (s2_load) begin
            out_vld_d = 1'b1;
        end else if (out_ready) begin
            out_vld_d = 1'b0;
        end
    end

    // Clear wins over a same-cycle erroring handshake.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (out_vld_q && out_ready && (out_err_q != ERR_OK) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q   <= 1'b0;
            out_instr_q <= 32'h0;
            out_err_q   <= ERR_OK;
            err_cnt_q   <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            err_cnt_q <= err_cnt_d;
            if (s2_load) begin
                out_instr_q <= pk_instr;
                out_err_q   <= pk_err;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed vector table plus hand-written sequences for backpressure, counter saturation/clear,
// asynchronous reset and a randomized round-trip against an immediate-extender model.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  immsrc = 3'b000;
    logic [31:0] imm = 32'h0;
    logic [31:0] tmpl = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [1:0]  out_err;
    logic [7:0]  err_count;
    logic        err_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    imm_encoder #(.ERRW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .immsrc    (immsrc),
        .imm       (imm),
        .tmpl      (tmpl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] tmpl;
        logic [31:0] instr;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] s);
        logic [31:0] r;
        case (s)
            3'b000:  r = {{20{i[31]}}, i[31:20]};
            3'b001:  r = {{20{i[31]}}, i[31:25], i[11:7]};
            3'b010:  r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'b011:  r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = {i[31:12], 12'h000};
        endcase
        return r;
    endfunction

    // One isolated request with out_ready high; lat counts cycles from accept to out_valid.
    task automatic send(input logic [2:0] s, input logic [31:0] v, input logic [31:0] t,
                        output logic [31:0] gi, output logic [1:0] ge, output int lat);
        @(negedge clk);
        immsrc = s; imm = v; tmpl = t; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        lat = 0;
        while (!in_ready && lat < 10) begin
            @(negedge clk); #1; lat++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        gi = out_instr;
        ge = out_err;
    endtask

    initial begin
        logic [31:0] gi;
        logic [1:0]  ge;
        int          lat;
        int          idx, nout, first_c, last_c, acc, cyc;
        logic        a, seen;
        logic [31:0] bp_exp[4];

        vecs[0]  = '{3'b000, 32'hFFFFF800, 32'h00000013, 32'h80000013, 2'b00};
        vecs[1]  = '{3'b000, 32'h00000800, 32'h00000013, 32'h80000013, 2'b01};
        vecs[2]  = '{3'b010, 32'h00000800, 32'h00000063, 32'h000000E3, 2'b00};
        vecs[3]  = '{3'b010, 32'hFFFFF000, 32'h00000063, 32'h80000063, 2'b00};
        vecs[4]  = '{3'b011, 32'h00000003, 32'h0000006F, 32'h0020006F, 2'b10};
        vecs[5]  = '{3'b100, 32'h12345000, 32'h000000B7, 32'h123450B7, 2'b00};
        vecs[6]  = '{3'b100, 32'h12345001, 32'h000000B7, 32'h123450B7, 2'b01};
        vecs[7]  = '{3'b111, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11};
        vecs[8]  = '{3'b001, 32'hFFFFFFFF, 32'h00000023, 32'hFE000FA3, 2'b00};
        vecs[9]  = '{3'b001, 32'h000007FF, 32'h00000023, 32'h7E000FA3, 2'b00};
        vecs[10] = '{3'b011, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 2'b00};
        vecs[11] = '{3'b011, 32'h00100000, 32'h0000006F, 32'h8000006F, 2'b01};
        vecs[12] = '{3'b010, 32'h00001001, 32'h00000063, 32'h80000063, 2'b10};
        vecs[13] = '{3'b101, 32'h00000001, 32'h12345678, 32'h12345678, 2'b11};
        vecs[14] = '{3'b000, 32'h00000000, 32'hFFFFFFFF, 32'h000FFFFF, 2'b00};
        vecs[15] = '{3'b001, 32'hFFFFF7FF, 32'h00000023, 32'h7E000FA3, 2'b01};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_instr", out_instr, 32'h0);
        check("rst out_err", 32'(out_err), 32'd0);
        check("rst err_count", 32'(err_count), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].src, vecs[i].imm, vecs[i].tmpl, gi, ge, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d instr", i), gi, vecs[i].instr);
            check($sformatf("vec%0d err", i), 32'(ge), 32'(vecs[i].err));
        end
        @(negedge clk);
        check("err_count after table", 32'(err_count), 32'd8);

        // Backpressure: 5 stalled cycles accept only two requests
        for (int k = 0; k < 4; k++) bp_exp[k] = (32'(k + 1) << 20) | 32'h13;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            immsrc = 3'b000; tmpl = 32'h13; imm = 32'(idx + 1); in_valid = (idx < 4);
            #1;
            a = in_valid & in_ready;
            @(posedge clk);
            if (a) idx++;
        end
        @(negedge clk);
        #1;
        check("bp accepted while stalled", 32'(idx), 32'd2);
        check("bp in_ready full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        nout = 0; first_c = -1; last_c = -1; cyc = 0;
        while (nout < 4 && cyc < 20) begin
            imm = 32'(idx + 1); in_valid = (idx < 4);
            #1;
            a = in_valid & in_ready;
            if (out_valid) begin
                check($sformatf("bp out%0d", nout), out_instr, bp_exp[nout]);
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                nout++;
            end
            @(posedge clk);
            if (a) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("bp outputs", 32'(nout), 32'd4);
        check("bp back-to-back span", 32'(last_c - first_c), 32'd3);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("bp no duplicate", 32'(seen), 32'd0);

        // Counter clear, saturation and clear-vs-increment priority
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("err_clr alone", 32'(err_count), 32'd0);
        acc = 0; cyc = 0;
        immsrc = 3'b111; tmpl = 32'h0; out_ready = 1'b1;
        while (acc < 300 && cyc < 1000) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            a = in_ready;
            @(posedge clk);
            if (a) acc++;
            cyc++;
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("sat accepted", 32'(acc), 32'd300);
        check("sat err_count", 32'(err_count), 32'd255);

        out_ready = 1'b0;
        immsrc = 3'b110; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        check("clr-vs-inc out_valid held", 32'(out_valid), 32'd1);
        out_ready = 1'b1; err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk); err_clr = 1'b0;
        check("clr-vs-inc err_count", 32'(err_count), 32'd0);
        check("clr-vs-inc consumed", 32'(out_valid), 32'd0);

        // Asynchronous reset with both stages full
        send(3'b111, 32'h0, 32'h0, gi, ge, lat);
        @(negedge clk);
        check("pre-rst err_count", 32'(err_count), 32'd1);
        out_ready = 1'b0;
        immsrc = 3'b000; tmpl = 32'h13; imm = 32'h5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); imm = 32'h6;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        check("full out_valid", 32'(out_valid), 32'd1);
        check("full in_ready", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_instr", out_instr, 32'h0);
        check("async rst err_count", 32'(err_count), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); reset = 1'b0; out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no stale output after reset", 32'(seen), 32'd0);
        send(vecs[5].src, vecs[5].imm, vecs[5].tmpl, gi, ge, lat);
        check("post-rst instr", gi, vecs[5].instr);

        // Random round-trip against the extender model
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  s;
            logic [31:0] r, v;
            int          kind;
            s = 3'($urandom_range(0, 4));
            kind = int'($urandom_range(0, 3));
            r = $urandom;
            case (s)
                3'b000, 3'b001: v = {{20{r[11]}}, r[11:0]};
                3'b010:         v = {{19{r[12]}}, r[12:1], 1'b0};
                3'b011:         v = {{11{r[20]}}, r[20:1], 1'b0};
                default:        v = {r[31:12], 12'h000};
            endcase
            if (kind == 0) v = $urandom;
            send(s, v, $urandom, gi, ge, lat);
            if (kind != 0) check($sformatf("rnd%0d err", n), 32'(ge), 32'd0);
            if (ge == 2'b00) check($sformatf("rnd%0d roundtrip src%0d", n, s), extend(gi, s), v);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
